// File: rtl/spi_flash_bus_bridge_if.sv
// Bus bundle between the 6809 side / SPI flash controller and the bridge.
// The bridge takes the slave view; the CPU and controller drive the master view.
interface spi_flash_bus_bridge_if;
   logic        i_enable;
   logic        i_Q;
   logic [15:0] i_ADDRESS_BUS;
   logic        i_RW;
   logic        i_MemoryReady;
   logic [7:0]  i_spi_data;
   logic        i_timeout_clr;
   logic        o_spi_ce;
   logic        o_MRDY;
   logic [7:0]  o_DataBus;
   logic        o_data_oe;
   logic        o_timeout;

   modport master (
      output i_enable, i_Q, i_ADDRESS_BUS, i_RW, i_MemoryReady, i_spi_data, i_timeout_clr,
      input  o_spi_ce, o_MRDY, o_DataBus, o_data_oe, o_timeout
   );

   modport slave (
      input  i_enable, i_Q, i_ADDRESS_BUS, i_RW, i_MemoryReady, i_spi_data, i_timeout_clr,
      output o_spi_ce, o_MRDY, o_DataBus, o_data_oe, o_timeout
   );
endinterface

// File: rtl/spi_flash_bus_bridge.sv
// Bridges 6809 accesses in a 4 KB window onto one SPI flash request each,
// stretching E via MRDY until the controller finishes or a watchdog fires.
module spi_flash_bus_bridge #(
   parameter logic [15:0] BASE_ADDR    = 16'hE000,
   parameter int          ACK_TIMEOUT  = 16,
   parameter int          BUSY_TIMEOUT = 2048,
   parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
   input logic                   clk,
   input logic                   reset,
   spi_flash_bus_bridge_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      BUSY,
      TOUT,
      DONE
   } state_t;

   localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [15:0] r_cnt;
   logic [15:0] w_nextCnt;
   logic [15:0] w_cntInc;
   logic        r_rwLat;
   logic        w_nextRwLat;
   logic        r_spiCe;
   logic        w_nextSpiCe;
   logic        r_mrdy;
   logic        w_nextMrdy;
   logic [7:0]  r_dataBus;
   logic [7:0]  w_nextDataBus;
   logic        r_dataOe;
   logic        w_nextDataOe;
   logic        r_timeout;
   logic        w_nextTimeout;
   logic        w_hit;

   assign w_hit    = (bus.i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12]) && bus.i_enable && bus.i_Q;
   assign w_cntInc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

   assign bus.o_spi_ce  = r_spiCe;
   assign bus.o_MRDY    = r_mrdy;
   assign bus.o_DataBus = r_dataBus;
   assign bus.o_data_oe = r_dataOe;
   assign bus.o_timeout = r_timeout;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= 16'd0;
         r_rwLat   <= 1'b0;
         r_spiCe   <= 1'b0;
         r_mrdy    <= 1'b1;
         r_dataBus <= 8'h00;
         r_dataOe  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_rwLat   <= w_nextRwLat;
         r_spiCe   <= w_nextSpiCe;
         r_mrdy    <= w_nextMrdy;
         r_dataBus <= w_nextDataBus;
         r_dataOe  <= w_nextDataOe;
         r_timeout <= w_nextTimeout;
      end
   end

   // Outputs are derived from the next state so they appear registered with it;
   // a timeout set overrides a clear arriving in the same cycle.
   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextRwLat   = r_rwLat;
      w_nextDataBus = r_dataBus;
      w_nextTimeout = r_timeout & ~bus.i_timeout_clr;

      unique case (r_state)
         IDLE: begin
            if (w_hit) begin
               w_nextState = REQ;
               w_nextRwLat = bus.i_RW;
               w_nextCnt   = 16'd0;
            end
         end
         REQ: begin
            w_nextCnt = w_cntInc;
            if (!bus.i_MemoryReady) begin
               w_nextState = BUSY;
               w_nextCnt   = 16'd0;
            end else if (r_cnt == ACK_LAST) begin
               w_nextState = TOUT;
            end
         end
         BUSY: begin
            w_nextCnt = w_cntInc;
            if (bus.i_MemoryReady) begin
               w_nextState = DONE;
               if (r_rwLat) begin
                  w_nextDataBus = bus.i_spi_data;
               end
            end else if (r_cnt == BUSY_LAST) begin
               w_nextState = TOUT;
            end
         end
         TOUT: begin
            w_nextTimeout = 1'b1;
            w_nextState   = DONE;
            if (r_rwLat) begin
               w_nextDataBus = TIMEOUT_DATA;
            end
         end
         DONE: begin
            if (!bus.i_enable) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase

      w_nextSpiCe  = (w_nextState == REQ);
      w_nextMrdy   = !(w_nextState inside {REQ, BUSY, TOUT});
      w_nextDataOe = (w_nextState == DONE) && w_nextRwLat;
   end

endmodule

// File: tb/tb_spi_flash_bus_bridge.sv
// Self-checking bench: a flag-based transaction model checked every cycle,
// a scripted flash-controller responder, and directed literal checks per scenario.
module tb_spi_flash_bus_bridge;

   localparam int ACK_TO  = 16;
   localparam int BUSY_TO = 2048;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   spi_flash_bus_bridge_if bus ();

   spi_flash_bus_bridge #(
      .BASE_ADDR   (16'hE000),
      .ACK_TIMEOUT (ACK_TO),
      .BUSY_TIMEOUT(BUSY_TO),
      .TIMEOUT_DATA(8'hFF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller responder configuration, written only by the stimulus process.
   bit       ctrlEnable;
   bit       ctrlAbort;
   int       ctrlAckDelay;
   int       ctrlBusyLen;
   bit [7:0] ctrlData;
   bit       cActive;
   int       cCount;

   // Model state: one in-flight bus access described by flags and a wait count.
   bit       modelValid;
   bit       mActive;
   bit       mRead;
   bit       mAcked;
   bit       mTimeoutStep;
   bit       mReleased;
   int       mWait;
   bit       mTimeout;
   bit [7:0] mData;
   bit       mHit;

   // Observation counters accumulated over the whole run.
   int       pulseCount;
   int       ceHighCycles;
   int       mrdyLowCycles;
   int       oeHighCycles;
   bit       prevCe;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] addr, input logic rw, input logic e, input logic q);
      @(negedge clk);
      bus.i_ADDRESS_BUS = addr;
      bus.i_RW          = rw;
      bus.i_enable      = e;
      bus.i_Q           = q;
   endtask

   task automatic waitMrdy(input logic val, input int budget, input string name);
      int n;
      n = 0;
      while (bus.o_MRDY !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 16'(bus.o_MRDY), 16'(val));
   endtask

   // Flash controller: drops MemoryReady ctrlAckDelay clocks after seeing spi_ce,
   // raises it again ctrlBusyLen clocks later along with the read byte.
   initial begin
      bus.i_MemoryReady = 1'b1;
      bus.i_spi_data    = 8'h00;
      cActive           = 1'b0;
      cCount            = 0;
      forever begin
         @(negedge clk);
         if (ctrlAbort) begin
            cActive           = 1'b0;
            cCount            = 0;
            bus.i_MemoryReady = 1'b1;
         end else if (!cActive) begin
            if (ctrlEnable && bus.o_spi_ce === 1'b1) begin
               cActive = 1'b1;
               cCount  = 0;
            end
         end else begin
            cCount++;
         end
         if (cActive && !ctrlAbort) begin
            if (cCount == ctrlAckDelay) bus.i_MemoryReady = 1'b0;
            if (cCount == ctrlAckDelay + ctrlBusyLen) begin
               bus.i_MemoryReady = 1'b1;
               bus.i_spi_data    = ctrlData;
               cActive           = 1'b0;
            end
         end
      end
   end

   // Reference model: an access is requested until acked, busy until ready,
   // released (MRDY high) on completion or one cycle after a watchdog expiry.
   always @(posedge clk) begin
      mHit = (bus.i_ADDRESS_BUS[15:12] == 4'hE) && bus.i_enable && bus.i_Q;
      if (!reset) begin
         modelValid   = 1'b1;
         mActive      = 1'b0;
         mAcked       = 1'b0;
         mTimeoutStep = 1'b0;
         mReleased    = 1'b0;
         mWait        = 0;
         mTimeout     = 1'b0;
         mData        = 8'h00;
         mRead        = 1'b0;
      end else begin
         if (bus.i_timeout_clr) mTimeout = 1'b0;
         if (!mActive) begin
            if (mHit) begin
               mActive      = 1'b1;
               mRead        = bus.i_RW;
               mAcked       = 1'b0;
               mReleased    = 1'b0;
               mTimeoutStep = 1'b0;
               mWait        = 0;
            end
         end else if (mReleased) begin
            if (!bus.i_enable) mActive = 1'b0;
         end else if (mTimeoutStep) begin
            mTimeoutStep = 1'b0;
            mReleased    = 1'b1;
            mTimeout     = 1'b1;
            if (mRead) mData = 8'hFF;
         end else if (!mAcked) begin
            mWait++;
            if (!bus.i_MemoryReady) begin
               mAcked = 1'b1;
               mWait  = 0;
            end else if (mWait == ACK_TO) begin
               mTimeoutStep = 1'b1;
            end
         end else begin
            mWait++;
            if (bus.i_MemoryReady) begin
               mReleased = 1'b1;
               if (mRead) mData = bus.i_spi_data;
            end else if (mWait == BUSY_TO) begin
               mTimeoutStep = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, plus activity counters.
   always begin
      @(posedge clk);
      #2;
      if (modelValid) begin
         checkOutput("cyc_spi_ce",  16'(bus.o_spi_ce),  16'(mActive && !mAcked && !mTimeoutStep && !mReleased));
         checkOutput("cyc_mrdy",    16'(bus.o_MRDY),    16'(!(mActive && !mReleased)));
         checkOutput("cyc_data_oe", 16'(bus.o_data_oe), 16'(mActive && mReleased && mRead));
         checkOutput("cyc_databus", 16'(bus.o_DataBus), 16'(mData));
         checkOutput("cyc_timeout", 16'(bus.o_timeout), 16'(mTimeout));
      end
      if (bus.o_spi_ce === 1'b1) ceHighCycles++;
      if (bus.o_spi_ce === 1'b1 && !prevCe) pulseCount++;
      prevCe = (bus.o_spi_ce === 1'b1);
      if (bus.o_MRDY === 1'b0) mrdyLowCycles++;
      if (bus.o_data_oe === 1'b1) oeHighCycles++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin
      int p0;
      int c0;
      int m0;
      int o0;
      checks            = 0;
      failures          = 0;
      reset             = 1'b0;
      bus.i_enable      = 1'b0;
      bus.i_Q           = 1'b0;
      bus.i_ADDRESS_BUS = 16'h0000;
      bus.i_RW          = 1'b1;
      bus.i_timeout_clr = 1'b0;
      ctrlEnable        = 1'b1;
      ctrlAbort         = 1'b0;
      ctrlAckDelay      = 2;
      ctrlBusyLen       = 80;
      ctrlData          = 8'hA5;

      repeat (3) @(negedge clk);
      checkOutput("rst_mrdy",    16'(bus.o_MRDY),    16'd1);
      checkOutput("rst_spi_ce",  16'(bus.o_spi_ce),  16'd0);
      checkOutput("rst_data_oe", 16'(bus.o_data_oe), 16'd0);
      checkOutput("rst_databus", 16'(bus.o_DataBus), 16'h00);
      checkOutput("rst_timeout", 16'(bus.o_timeout), 16'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] scenario 1: read hit at E123");
      p0 = pulseCount; c0 = ceHighCycles; m0 = mrdyLowCycles;
      applyStimulus(16'hE123, 1'b1, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t1_mrdy_low");
      waitMrdy(1'b1, 200, "t1_mrdy_release");
      checkOutput("t1_pulses",    16'(pulseCount - p0),    16'd1);
      checkOutput("t1_ce_cycles", 16'(ceHighCycles - c0),  16'd3);
      checkOutput("t1_mrdy_low_cycles", 16'(mrdyLowCycles - m0), 16'd83);
      checkOutput("t1_databus",   16'(bus.o_DataBus),      16'h00A5);
      checkOutput("t1_data_oe",   16'(bus.o_data_oe),      16'd1);
      checkOutput("t1_timeout",   16'(bus.o_timeout),      16'd0);
      repeat (3) @(negedge clk);
      checkOutput("t1_oe_hold",   16'(bus.o_data_oe),      16'd1);
      applyStimulus(16'hE123, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t1_oe_drop",   16'(bus.o_data_oe),      16'd0);
      checkOutput("t1_data_keep", 16'(bus.o_DataBus),      16'h00A5);

      $display("[TB] scenario 2: write hit at EFFF");
      ctrlBusyLen = 10;
      ctrlData    = 8'h77;
      p0 = pulseCount; o0 = oeHighCycles;
      applyStimulus(16'hEFFF, 1'b0, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t2_mrdy_low");
      waitMrdy(1'b1, 50, "t2_mrdy_release");
      checkOutput("t2_mr_high",   16'(bus.i_MemoryReady),  16'd1);
      checkOutput("t2_pulses",    16'(pulseCount - p0),    16'd1);
      checkOutput("t2_databus",   16'(bus.o_DataBus),      16'h00A5);
      applyStimulus(16'hEFFF, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("t2_oe_cycles", 16'(oeHighCycles - o0),  16'd0);

      $display("[TB] scenario 3: accesses outside the window");
      p0 = pulseCount; m0 = mrdyLowCycles; o0 = oeHighCycles;
      applyStimulus(16'hD000, 1'b1, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      applyStimulus(16'hF000, 1'b1, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      applyStimulus(16'hF000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_pulses",    16'(pulseCount - p0),    16'd0);
      checkOutput("t3_mrdy_low",  16'(mrdyLowCycles - m0), 16'd0);
      checkOutput("t3_oe_cycles", 16'(oeHighCycles - o0),  16'd0);

      // Released 18 clk after the hit is presented: hit cycle + 16 REQ + 1 TOUT.
      $display("[TB] scenario 4: controller never acknowledges");
      ctrlEnable = 1'b0;
      m0 = mrdyLowCycles;
      applyStimulus(16'hE200, 1'b1, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t4_mrdy_low");
      waitMrdy(1'b1, 40, "t4_mrdy_release");
      checkOutput("t4_mrdy_low_cycles", 16'(mrdyLowCycles - m0), 16'd17);
      checkOutput("t4_databus",   16'(bus.o_DataBus),      16'h00FF);
      checkOutput("t4_data_oe",   16'(bus.o_data_oe),      16'd1);
      checkOutput("t4_timeout",   16'(bus.o_timeout),      16'd1);
      applyStimulus(16'hE200, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("t4_sticky",    16'(bus.o_timeout),      16'd1);
      bus.i_timeout_clr = 1'b1;
      @(negedge clk);
      bus.i_timeout_clr = 1'b0;
      checkOutput("t4_cleared",   16'(bus.o_timeout),      16'd0);
      bus.i_timeout_clr = 1'b1;
      applyStimulus(16'hE400, 1'b1, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t4b_mrdy_low");
      waitMrdy(1'b1, 40, "t4b_mrdy_release");
      checkOutput("t4b_set_wins", 16'(bus.o_timeout),      16'd1);
      @(negedge clk);
      checkOutput("t4b_clr_after", 16'(bus.o_timeout),     16'd0);
      bus.i_timeout_clr = 1'b0;
      applyStimulus(16'hE400, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      $display("[TB] scenario 5: reset during BUSY");
      ctrlEnable  = 1'b1;
      ctrlBusyLen = 80;
      ctrlData    = 8'h5A;
      applyStimulus(16'hE300, 1'b1, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t5_mrdy_low");
      repeat (10) @(negedge clk);
      checkOutput("t5_in_busy_mr", 16'(bus.i_MemoryReady), 16'd0);
      reset     = 1'b0;
      ctrlAbort = 1'b1;
      @(negedge clk);
      checkOutput("t5_rst_mrdy",    16'(bus.o_MRDY),     16'd1);
      checkOutput("t5_rst_spi_ce",  16'(bus.o_spi_ce),   16'd0);
      checkOutput("t5_rst_data_oe", 16'(bus.o_data_oe),  16'd0);
      checkOutput("t5_rst_databus", 16'(bus.o_DataBus),  16'h00);
      @(negedge clk);
      p0        = pulseCount;
      reset     = 1'b1;
      ctrlAbort = 1'b0;
      waitMrdy(1'b0, 4, "t5_restart_low");
      waitMrdy(1'b1, 200, "t5_restart_release");
      checkOutput("t5_databus",   16'(bus.o_DataBus),      16'h005A);
      applyStimulus(16'hE300, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("t5_pulses",    16'(pulseCount - p0),    16'd1);

      $display("[TB] scenario 6: back-to-back reads E000 then E001");
      ctrlBusyLen = 6;
      ctrlData    = 8'h3C;
      p0 = pulseCount;
      applyStimulus(16'hE000, 1'b1, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t6a_mrdy_low");
      waitMrdy(1'b1, 40, "t6a_mrdy_release");
      checkOutput("t6a_databus",  16'(bus.o_DataBus),      16'h003C);
      applyStimulus(16'hE001, 1'b1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      checkOutput("t6_done_no_req", 16'(pulseCount - p0),  16'd1);
      checkOutput("t6_done_mrdy", 16'(bus.o_MRDY),         16'd1);
      applyStimulus(16'hE001, 1'b1, 1'b0, 1'b1);
      ctrlData = 8'hC3;
      repeat (3) @(negedge clk);
      applyStimulus(16'hE001, 1'b1, 1'b1, 1'b1);
      waitMrdy(1'b0, 4, "t6b_mrdy_low");
      waitMrdy(1'b1, 40, "t6b_mrdy_release");
      checkOutput("t6b_databus",  16'(bus.o_DataBus),      16'h00C3);
      applyStimulus(16'hE001, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("t6_pulses",    16'(pulseCount - p0),    16'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_flash_bus_bridge.md
Name: spi_flash_bus_bridge

Overview:
- Sits between the 6809 bus and the SPI flash controller.
- Decodes the 4 KB flash window and qualifies each access with E and Q.
- Issues a single `spi_ce` request per bus cycle, then holds MRDY low until the controller finishes.
- Latches read data and drives it onto the CPU data bus for the rest of the E-high phase. A watchdog prevents the CPU from stalling forever if the controller never responds.

Parameters:
- BASE_ADDR, 16'hE000: window base; only bits [15:12] are compared, giving a 4 KB window.
- ACK_TIMEOUT, 16: max clk cycles in REQ waiting for `i_MemoryReady` to go low.
- BUSY_TIMEOUT, 2048: max clk cycles in BUSY waiting for `i_MemoryReady` to return high.
- TIMEOUT_DATA, 8'hFF: data returned on a timed-out read.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- i_enable  input  1  6809 E clock
- i_Q  input  1  6809 Q clock
- i_ADDRESS_BUS  input  16  CPU address
- i_RW  input  1  1 = read, 0 = write
- i_MemoryReady  input  1  from flash controller; low = transaction in progress
- i_spi_data  input  8  read byte from flash controller
- i_timeout_clr  input  1  clears sticky timeout flag
- o_spi_ce  output  1  request strobe to flash controller
- o_MRDY  output  1  to CPU MRDY; low stretches E
- o_DataBus  output  8  read data toward CPU
- o_data_oe  output  1  data bus output enable (read hits only)
- o_timeout  output  1  sticky watchdog flag

Behaviour:
- All outputs are registered.
- Reset (reset=0 at posedge clk) forces state IDLE and sets:
  - o_spi_ce=0, o_MRDY=1, o_DataBus=8'h00, o_data_oe=0, o_timeout=0
  - counters cleared
- Reset mid-transaction aborts immediately; no SPI request is reissued.
- hit = (i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12]) && i_enable && i_Q.
- rw_lat and counter cnt are internal registers.

State IDLE:
- o_spi_ce=0, o_MRDY=1, o_data_oe=0.
- On hit: latch rw_lat=i_RW, clear cnt, go to REQ.
- Next cycle: o_spi_ce=1 and o_MRDY=0, i.e. 1 clk latency from hit to MRDY low.

State REQ:
- o_spi_ce=1, o_MRDY=0, cnt increments each cycle.
- If i_MemoryReady=0: o_spi_ce=0 on the next cycle, clear cnt, go to BUSY.
- Else if cnt == ACK_TIMEOUT-1: go to TOUT.
- o_spi_ce is never held high after the ack is seen. The controller restarts on spi_ce while idle, so this guarantees exactly one SPI transaction per bus cycle.

State BUSY:
- o_spi_ce=0, o_MRDY=0, cnt increments.
- If i_MemoryReady=1: o_DataBus <= i_spi_data when rw_lat=1, go to DONE.
- Else if cnt == BUSY_TIMEOUT-1: go to TOUT.

State TOUT (one cycle):
- o_timeout <= 1.
- o_DataBus <= TIMEOUT_DATA when rw_lat=1.
- Go to DONE.

State DONE:
- o_MRDY=1; o_data_oe=rw_lat.
- Remain while i_enable=1.
- When i_enable=0: o_data_oe=0 the next cycle, go to IDLE.
- A hit is never accepted in DONE, even if the address changes. A new request requires passing through IDLE.

Timeout flag:
- o_timeout is sticky.
- Cleared by i_timeout_clr=1 in any state.
- If i_timeout_clr and a TOUT set occur in the same cycle, the set wins.

Write accesses:
- Same flow as reads; o_data_oe stays 0 and o_DataBus holds its previous value.

Data bus:
- o_DataBus retains its value between transactions; only o_data_oe gates the bus.

Counters:
- cnt is 16 bits, saturating, never wraps.
- ACK_TIMEOUT and BUSY_TIMEOUT must be >= 2.

Q/E skew:
- If hit is true for only 1 clk, the transaction still proceeds, since the qualification is latched at the IDLE->REQ transition.

Test Plan:
1. Read hit at 16'hE123; model drops MemoryReady 2 clk after spi_ce and raises it 80 clk later with data 8'hA5 -> o_spi_ce high exactly 3 clk; MRDY low from hit+1 until BUSY exit; o_DataBus=8'hA5 with o_data_oe=1 until E falls; o_timeout=0.
2. Write hit at 16'hEFFF with i_RW=0 -> one spi_ce pulse; MRDY released after MemoryReady returns high; o_data_oe stays 0 throughout.
3. Access to 16'hD000 and 16'hF000 with E, Q high -> o_spi_ce=0, o_MRDY=1, o_data_oe=0 for all cycles.
4. Controller never acks (MemoryReady held 1) on a read -> MRDY released after ACK_TIMEOUT+2 clk; o_DataBus=8'hFF; o_timeout=1 and stays 1 until i_timeout_clr; same-cycle clear+set leaves o_timeout=1.
5. reset=0 asserted in BUSY -> next clk: o_MRDY=1, o_spi_ce=0, o_data_oe=0, state IDLE; after reset release with the address still a hit, a fresh request starts exactly once.
6. Two back-to-back read bus cycles to 16'hE000 and 16'hE001 with E low for 4 clk between them -> exactly two spi_ce pulses; no request is issued while in DONE with E high.
